// File: rtl/multicycle_control_fsm.sv
// Main control unit for a multicycle MIPS-subset datapath: a single state
// register, with every datapath control decoded from the current state and the handshake inputs.
module multicycle_control_fsm #(
  parameter int OPW = 6
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [OPW-1:0] Opcode,
  input  logic           Zero,
  input  logic           MemReady,
  output logic           IRWrite,
  output logic           PCEn,
  output logic           MemWrite,
  output logic           RegWrite,
  output logic           IorD,
  output logic           ALUSrcA,
  output logic           RegDst,
  output logic           MemtoReg,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     PCSrc,
  output logic [1:0]     ALUOp,
  output logic           InstrDone,
  output logic           Illegal,
  output logic [3:0]     State
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);

  state_t state_q;
  state_t state_d;

  logic irWrite;
  logic pcEn;
  logic memWrite;
  logic regWrite;
  logic instrDone;
  logic illegalOp;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode; anything not set in a state stays 0.
  always_comb begin
    state_d   = FETCH;
    irWrite   = 1'b0;
    pcEn      = 1'b0;
    memWrite  = 1'b0;
    regWrite  = 1'b0;
    instrDone = 1'b0;
    illegalOp = 1'b0;
    IorD      = 1'b0;
    ALUSrcA   = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    ALUSrcB   = 2'b00;
    PCSrc     = 2'b00;
    ALUOp     = 2'b00;

    case (state_q)
      FETCH: begin
        ALUSrcB = 2'b01;
        irWrite = MemReady;
        pcEn    = MemReady;
        state_d = MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default: begin
            illegalOp = 1'b1;
            state_d   = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (Opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        IorD    = 1'b1;
        state_d = MemReady ? MEMWB : MEMRD;
      end
      MEMWB: begin
        MemtoReg  = 1'b1;
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      // The store is held on the bus until memory accepts it.
      MEMWR: begin
        IorD      = 1'b1;
        memWrite  = 1'b1;
        instrDone = MemReady;
        state_d   = MemReady ? FETCH : MEMWR;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = ALUWB;
      end
      ALUWB: begin
        RegDst    = 1'b1;
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      BRANCH: begin
        ALUSrcA   = 1'b1;
        ALUOp     = 2'b01;
        PCSrc     = 2'b01;
        pcEn      = Zero;
        instrDone = 1'b1;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      JUMP: begin
        PCSrc     = 2'b10;
        pcEn      = 1'b1;
        instrDone = 1'b1;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Reset already parks the state in FETCH, but FETCH enables follow MemReady,
  // so every enable and pulse is also qualified with RST.
  assign IRWrite   = irWrite   & RST;
  assign PCEn      = pcEn      & RST;
  assign MemWrite  = memWrite  & RST;
  assign RegWrite  = regWrite  & RST;
  assign InstrDone = instrDone & RST;
  assign Illegal   = illegalOp & RST;
  assign State     = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: directed instruction runs with
// literal expectations, then randomized traffic against an instruction-level model.
module tb_multicycle_control_fsm;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic       CLK;
  logic       RST;
  logic [5:0] Opcode;
  logic       Zero;
  logic       MemReady;
  logic       IRWrite, PCEn, MemWrite, RegWrite;
  logic       IorD, ALUSrcA, RegDst, MemtoReg;
  logic [1:0] ALUSrcB, PCSrc, ALUOp;
  logic       InstrDone, Illegal;
  logic [3:0] State;

  int checks = 0;
  int errors = 0;

  // Model: current step of the instruction plus the queue of steps still to run.
  int mState = 0;
  int path[$];
  bit compareOn = 0;

  int trace[$];
  int nRegWrite, nRwM2r, nRwDst, rwState, nDone, nIllegal, nEnNonFetch, n3;
  int memWriteRun, maxMemWriteRun;
  int bPCEn, bPCSrc, jPCEn, jPCSrc;

  logic [5:0] legalOps [6];
  logic [19:0] dutVec;

  multicycle_control_fsm #(.OPW(6)) dut (
    .CLK(CLK), .RST(RST), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .IRWrite(IRWrite), .PCEn(PCEn), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .IorD(IorD), .ALUSrcA(ALUSrcA), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUOp(ALUOp),
    .InstrDone(InstrDone), .Illegal(Illegal), .State(State)
  );

  assign dutVec = {IRWrite, PCEn, MemWrite, RegWrite, IorD, ALUSrcA, RegDst, MemtoReg,
                   ALUSrcB, PCSrc, ALUOp, InstrDone, Illegal, State};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit isLegal(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_J);
  endfunction

  // Control word each step must show, written straight from the step descriptions.
  function automatic logic [19:0] expOut(input int s, input logic [5:0] op, input logic z,
                                         input logic mr, input logic rstn);
    logic irw = 0, pce = 0, mw = 0, rw = 0, iord = 0, srca = 0, rdst = 0, m2r = 0;
    logic done = 0, ill = 0;
    logic [1:0] srcb = 0, pcs = 0, aop = 0;
    case (s)
      0:  begin srcb = 2'b01; irw = mr; pce = mr; end
      1:  begin srcb = 2'b11; ill = !isLegal(op); end
      2:  begin srca = 1; srcb = 2'b10; end
      3:  begin iord = 1; end
      4:  begin m2r = 1; rw = 1; done = 1; end
      5:  begin iord = 1; mw = 1; done = mr; end
      6:  begin srca = 1; aop = 2'b10; end
      7:  begin rdst = 1; rw = 1; done = 1; end
      8:  begin srca = 1; aop = 2'b01; pcs = 2'b01; pce = z; done = 1; end
      9:  begin srca = 1; srcb = 2'b10; end
      10: begin rw = 1; done = 1; end
      11: begin pcs = 2'b10; pce = 1; done = 1; end
      default: ;
    endcase
    if (!rstn) begin
      irw = 0;
      pce = 0;
    end
    return {irw, pce, mw, rw, iord, srca, rdst, m2r, srcb, pcs, aop, done, ill, 4'(s)};
  endfunction

  function automatic int nextFromPath();
    if (path.size() > 0) return path.pop_front();
    return 0;
  endfunction

  task automatic modelStep();
    case (mState)
      0: if (MemReady) mState = 1;
      1: begin
        path.delete();
        if (Opcode == OP_LW || Opcode == OP_SW) path = {2};
        else if (Opcode == OP_R)    path = {6, 7};
        else if (Opcode == OP_BEQ)  path = {8};
        else if (Opcode == OP_ADDI) path = {9, 10};
        else if (Opcode == OP_J)    path = {11};
        mState = nextFromPath();
      end
      2: begin
        if (Opcode == OP_LW) path = {3, 4};
        else path = {5};
        mState = nextFromPath();
      end
      3, 5: if (MemReady) mState = nextFromPath();
      default: mState = nextFromPath();
    endcase
  endtask

  task automatic tick();
    @(posedge CLK);
    if (RST) modelStep();
    #1;
  endtask

  always @(negedge CLK) begin
    if (compareOn)
      checkOutput("cycleOutputs", 32'(dutVec), 32'(expOut(mState, Opcode, Zero, MemReady, RST)));
  end

  task automatic applyReset();
    RST = 1'b0;
    mState = 0;
    path.delete();
    #1;
    checkOutput("resetEnables", 32'({IRWrite, PCEn, MemWrite, RegWrite, InstrDone, Illegal}), 32'd0);
    checkOutput("resetState", 32'(State), 32'd0);
    repeat (2) tick();
    RST = 1'b1;
  endtask

  task automatic sampleCycle();
    trace.push_back(int'(State));
    if (RegWrite) begin
      nRegWrite++;
      rwState = int'(State);
    end
    if (RegWrite && MemtoReg) nRwM2r++;
    if (RegWrite && RegDst) nRwDst++;
    if (MemWrite) memWriteRun++; else memWriteRun = 0;
    if (memWriteRun > maxMemWriteRun) maxMemWriteRun = memWriteRun;
    if (InstrDone) nDone++;
    if (Illegal) nIllegal++;
    if (State != 4'd0 && (IRWrite || PCEn || MemWrite || RegWrite)) nEnNonFetch++;
    if (State == 4'd3) n3++;
    if (State == 4'd8) begin bPCEn = int'(PCEn); bPCSrc = int'(PCSrc); end
    if (State == 4'd11) begin jPCEn = int'(PCEn); jPCSrc = int'(PCSrc); end
  endtask

  // Runs one instruction from FETCH back to FETCH, stalling memory steps as asked.
  task automatic runInstr(input logic [5:0] op, input logic z, input int stall);
    int stalls = 0;
    int guard = 0;
    trace.delete();
    nRegWrite = 0; nRwM2r = 0; nRwDst = 0; rwState = -1; nDone = 0; nIllegal = 0;
    nEnNonFetch = 0; n3 = 0; memWriteRun = 0; maxMemWriteRun = 0;
    bPCEn = -1; bPCSrc = -1; jPCEn = -1; jPCSrc = -1;
    Opcode = op;
    Zero = z;
    do begin
      if ((mState == 3 || mState == 5) && stalls < stall) begin
        MemReady = 1'b0;
        stalls++;
      end else begin
        MemReady = 1'b1;
      end
      #1;
      sampleCycle();
      tick();
      guard++;
    end while (mState != 0 && guard < 30);
    MemReady = 1'b1;
    #1;
    trace.push_back(int'(State));
    if (guard >= 30) checkOutput("runInstrTimeout", 32'(guard), 32'd0);
  endtask

  function automatic logic [31:0] traceWord();
    logic [31:0] w = 0;
    foreach (trace[i]) w = (w << 4) | 32'(trace[i] & 15);
    return w;
  endfunction

  task automatic applyStimulus(input int nCycles);
    for (int c = 0; c < nCycles; c++) begin
      if ($urandom_range(0, 199) == 0) applyReset();
      if (mState == 0) begin
        if ($urandom_range(0, 3) == 0) Opcode = 6'($urandom_range(0, 63));
        else Opcode = legalOps[$urandom_range(0, 5)];
      end
      MemReady = ($urandom_range(0, 3) != 0);
      Zero = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  initial begin
    int guard;
    legalOps = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    RST = 1'b1;
    Opcode = OP_R;
    Zero = 1'b0;
    MemReady = 1'b1;
    #2;
    applyReset();
    compareOn = 1;

    runInstr(OP_R, 1'b0, 0);
    checkOutput("rtypeTrace", traceWord(), 32'h01670);
    checkOutput("rtypeLatency", 32'(trace.size() - 1), 32'd4);
    checkOutput("rtypeRegWrites", 32'(nRegWrite), 32'd1);
    checkOutput("rtypeRegDstWrite", 32'(nRwDst), 32'd1);
    checkOutput("rtypeWriteState", 32'(rwState), 32'd7);
    checkOutput("rtypeDonePulses", 32'(nDone), 32'd1);

    runInstr(OP_LW, 1'b0, 0);
    checkOutput("lwTrace", traceWord(), 32'h012340);
    checkOutput("lwLatency", 32'(trace.size() - 1), 32'd5);

    runInstr(OP_LW, 1'b0, 3);
    checkOutput("lwStallMemrdCycles", 32'(n3), 32'd4);
    checkOutput("lwStallLoadWrites", 32'(nRwM2r), 32'd1);
    checkOutput("lwStallRegWrites", 32'(nRegWrite), 32'd1);

    runInstr(OP_SW, 1'b0, 0);
    checkOutput("swTrace", traceWord(), 32'h01250);
    checkOutput("swLatency", 32'(trace.size() - 1), 32'd4);

    runInstr(OP_SW, 1'b0, 2);
    checkOutput("swStallMemWriteRun", 32'(maxMemWriteRun), 32'd3);
    checkOutput("swStallRegWrites", 32'(nRegWrite), 32'd0);
    checkOutput("swStallDonePulses", 32'(nDone), 32'd1);

    runInstr(OP_BEQ, 1'b1, 0);
    checkOutput("beqTrace", traceWord(), 32'h0180);
    checkOutput("beqLatency", 32'(trace.size() - 1), 32'd3);
    checkOutput("beqTakenPCEn", 32'(bPCEn), 32'd1);
    checkOutput("beqTakenPCSrc", 32'(bPCSrc), 32'd1);

    runInstr(OP_BEQ, 1'b0, 0);
    checkOutput("beqNotTakenPCEn", 32'(bPCEn), 32'd0);

    runInstr(OP_ADDI, 1'b0, 0);
    checkOutput("addiTrace", traceWord(), 32'h019A0);
    checkOutput("addiLatency", 32'(trace.size() - 1), 32'd4);

    runInstr(OP_J, 1'b0, 0);
    checkOutput("jumpTrace", traceWord(), 32'h01B0);
    checkOutput("jumpLatency", 32'(trace.size() - 1), 32'd3);
    checkOutput("jumpPCEn", 32'(jPCEn), 32'd1);
    checkOutput("jumpPCSrc", 32'(jPCSrc), 32'd2);

    runInstr(6'b111111, 1'b0, 0);
    checkOutput("illegalTrace", traceWord(), 32'h010);
    checkOutput("illegalPulses", 32'(nIllegal), 32'd1);
    checkOutput("illegalEnables", 32'(nEnNonFetch), 32'd0);

    // Abort an R-type in its write-back step, then confirm a clean restart.
    Opcode = OP_R;
    MemReady = 1'b1;
    guard = 0;
    while (mState != 7 && guard < 10) begin
      tick();
      guard++;
    end
    #1;
    checkOutput("aluwbReached", 32'(State), 32'd7);
    checkOutput("aluwbRegWrite", 32'(RegWrite), 32'd1);
    applyReset();
    #1;
    checkOutput("afterAbortState", 32'(State), 32'd0);
    runInstr(OP_R, 1'b0, 0);
    checkOutput("afterAbortTrace", traceWord(), 32'h01670);
    checkOutput("afterAbortWriteState", 32'(rwState), 32'd7);
    checkOutput("afterAbortRegWrites", 32'(nRegWrite), 32'd1);

    applyStimulus(3000);
    @(negedge CLK);
    compareOn = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
